// File: rtl/me_feeder_pkg.sv
// rtl/me_feeder_pkg.sv - shared constants, FSM encoding and frame-bounds helper for me_feeder
package me_feeder_pkg;

  localparam int PIX_W    = 8;
  localparam int BLK_SIZE = 16;
  localparam int BS_SQ    = BLK_SIZE * BLK_SIZE;
  localparam int BS_CUBE  = BS_SQ * BLK_SIZE;
  localparam int COORD_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR       = 3'd1,
    ST_STREAM    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESULT    = 3'd5
  } state_t;

  function automatic logic out_of_frame(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input int fw, input int fh);
    return (int'(x) >= fw) || (int'(y) >= fh);
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// rtl/me_addr_gen.sv - j/r/col beat counters, frame address arithmetic and out-of-frame flags
module me_addr_gen #(
  parameter int BLK_SIZE = me_feeder_pkg::BLK_SIZE,
  parameter int FRAME_W  = 64,
  parameter int FRAME_H  = 64,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        blk_x,
  input  logic [7:0]        blk_y,
  input  logic [7:0]        win_x,
  input  logic [7:0]        win_y,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] ref_a_addr,
  output logic [ADDR_W-1:0] ref_b_addr,
  output logic              cur_oor,
  output logic              ref_a_oor,
  output logic              ref_b_oor,
  output logic              first,
  output logic              last
);
  import me_feeder_pkg::*;

  localparam int CNT_W = (BLK_SIZE > 1) ? $clog2(BLK_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLK_SIZE - 1);

  logic [CNT_W-1:0]   j, r, col;
  logic [COORD_W-1:0] j_w, r_w, col_w, bs_w;
  logic [COORD_W-1:0] cur_x, cur_y, ref_y, ref_a_x, ref_b_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j   <= '0;
      r   <= '0;
      col <= '0;
    end else if (clr) begin
      j   <= '0;
      r   <= '0;
      col <= '0;
    end else if (en) begin
      if (col == CNT_MAX) begin
        col <= '0;
        if (r == CNT_MAX) begin
          r <= '0;
          j <= (j == CNT_MAX) ? '0 : j + 1'b1;
        end else begin
          r <= r + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign j_w   = COORD_W'(j);
  assign r_w   = COORD_W'(r);
  assign col_w = COORD_W'(col);
  assign bs_w  = COORD_W'(BLK_SIZE);

  // 9-bit sums so that a window near the frame edge is detected, not wrapped
  assign cur_x   = {1'b0, blk_x} + col_w;
  assign cur_y   = {1'b0, blk_y} + r_w;
  assign ref_y   = {1'b0, win_y} + r_w;
  assign ref_a_x = {1'b0, win_x} + j_w + col_w;
  assign ref_b_x = {1'b0, win_x} + bs_w + j_w + col_w;

  function automatic logic [ADDR_W-1:0] lin(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
    logic [31:0] a;
    a = 32'(y) * 32'(FRAME_W) + 32'(x);
    return a[ADDR_W-1:0];
  endfunction

  assign cur_oor   = out_of_frame(cur_x, cur_y, FRAME_W, FRAME_H);
  assign ref_a_oor = out_of_frame(ref_a_x, ref_y, FRAME_W, FRAME_H);
  assign ref_b_oor = out_of_frame(ref_b_x, ref_y, FRAME_W, FRAME_H);

  assign cur_addr   = (en && !cur_oor)   ? lin(cur_x, cur_y)     : '0;
  assign ref_a_addr = (en && !ref_a_oor) ? lin(ref_a_x, ref_y)   : '0;
  assign ref_b_addr = (en && !ref_b_oor) ? lin(ref_b_x, ref_y)   : '0;

  assign first = (j == '0) && (r == '0) && (col == '0);
  assign last  = (j == CNT_MAX) && (r == CNT_MAX) && (col == CNT_MAX);

endmodule

// File: rtl/me_feeder.sv
// rtl/me_feeder.sv - sequences one pe_row search job: clear, stream beats, await done, return result
module me_feeder #(
  parameter int BLK_SIZE = me_feeder_pkg::BLK_SIZE,
  parameter int FRAME_W  = 64,
  parameter int FRAME_H  = 64,
  parameter int ADDR_W   = 12,
  parameter int TIMEOUT  = 8192
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_blk_x,
  input  logic [7:0]        req_blk_y,
  input  logic [7:0]        req_win_x,
  input  logic [7:0]        req_win_y,
  output logic [ADDR_W-1:0] cur_addr,
  input  logic [7:0]        cur_data,
  output logic [ADDR_W-1:0] ref_a_addr,
  input  logic [7:0]        ref_a_data,
  output logic [ADDR_W-1:0] ref_b_addr,
  input  logic [7:0]        ref_b_data,
  output logic              pe_reset,
  output logic              pe_start,
  output logic [7:0]        pe_c,
  output logic [7:0]        pe_p,
  output logic [7:0]        pe_p_prime,
  input  logic              pe_done,
  input  logic [7:0]        pe_m_i,
  input  logic [7:0]        pe_m_j,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_m_i,
  output logic [7:0]        res_m_j,
  output logic              res_err
);
  import me_feeder_pkg::*;

  localparam int TO_W = $clog2(TIMEOUT) + 1;

  state_t          state, state_nxt;
  logic [7:0]      blk_x, blk_y, win_x, win_y;
  logic            drain_cnt;
  logic [TO_W-1:0] wait_cnt;
  logic            timeout_hit;
  logic            clr_en, stream_en;
  logic            addr_first, addr_last;
  logic            cur_oor, ref_a_oor, ref_b_oor;
  logic            beat_v1, first_v1, cur_oor1, ref_a_oor1, ref_b_oor1;

  assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (req_valid) state_nxt = ST_CLR;
      ST_CLR:       state_nxt = ST_STREAM;
      ST_STREAM:    if (addr_last) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (drain_cnt) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (pe_done || timeout_hit) state_nxt = ST_RESULT;
      ST_RESULT:    if (res_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // pe_row is held in clear for as long as reset_n is low
  always_comb begin
    req_ready = 1'b0;
    pe_reset  = !reset_n;
    res_valid = 1'b0;
    clr_en    = 1'b0;
    stream_en = 1'b0;
    case (state)
      ST_IDLE:   req_ready = reset_n;
      ST_CLR: begin
        pe_reset = 1'b1;
        clr_en   = 1'b1;
      end
      ST_STREAM: stream_en = 1'b1;
      ST_RESULT: res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_x     <= '0;
      blk_y     <= '0;
      win_x     <= '0;
      win_y     <= '0;
      drain_cnt <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        blk_x <= req_blk_x;
        blk_y <= req_blk_y;
        win_x <= req_win_x;
        win_y <= req_win_y;
      end
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      wait_cnt  <= (state == ST_WAIT_DONE) ? wait_cnt + 1'b1 : '0;
    end
  end

  me_addr_gen #(
    .BLK_SIZE (BLK_SIZE),
    .FRAME_W  (FRAME_W),
    .FRAME_H  (FRAME_H),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr_en),
    .en         (stream_en),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .win_x      (win_x),
    .win_y      (win_y),
    .cur_addr   (cur_addr),
    .ref_a_addr (ref_a_addr),
    .ref_b_addr (ref_b_addr),
    .cur_oor    (cur_oor),
    .ref_a_oor  (ref_a_oor),
    .ref_b_oor  (ref_b_oor),
    .first      (addr_first),
    .last       (addr_last)
  );

  // Stage 1 lines up with memory read data; stage 2 is the registered beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_v1    <= 1'b0;
      first_v1   <= 1'b0;
      cur_oor1   <= 1'b0;
      ref_a_oor1 <= 1'b0;
      ref_b_oor1 <= 1'b0;
      pe_start   <= 1'b0;
      pe_c       <= '0;
      pe_p       <= '0;
      pe_p_prime <= '0;
    end else begin
      beat_v1    <= stream_en;
      first_v1   <= stream_en && addr_first;
      cur_oor1   <= cur_oor;
      ref_a_oor1 <= ref_a_oor;
      ref_b_oor1 <= ref_b_oor;
      pe_start   <= first_v1;
      if (beat_v1) begin
        pe_c       <= cur_oor1   ? '0 : cur_data;
        pe_p       <= ref_b_oor1 ? '0 : ref_b_data;
        pe_p_prime <= ref_a_oor1 ? '0 : ref_a_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_m_i <= '0;
      res_m_j <= '0;
      res_err <= 1'b0;
    end else if (state == ST_WAIT_DONE) begin
      if (pe_done) begin
        res_m_i <= pe_m_i;
        res_m_j <= pe_m_j;
        res_err <= 1'b0;
      end else if (timeout_hit) begin
        res_m_i <= '0;
        res_m_j <= '0;
        res_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_me_feeder.sv
// tb/tb_me_feeder.sv - self-checking bench for me_feeder with a beat scoreboard and job vector table
module tb_me_feeder;
  localparam int BS = 4;
  localparam int FW = 16;
  localparam int FH = 16;
  localparam int AW = 12;
  localparam int TO = 256;
  localparam int NB = BS * BS * BS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [7:0]    req_blk_x, req_blk_y, req_win_x, req_win_y;
  logic [AW-1:0] cur_addr, ref_a_addr, ref_b_addr;
  logic [7:0]    cur_data, ref_a_data, ref_b_data;
  logic          pe_reset, pe_start, pe_done;
  logic [7:0]    pe_c, pe_p, pe_p_prime, pe_m_i, pe_m_j;
  logic          res_valid, res_ready, res_err;
  logic [7:0]    res_m_i, res_m_j;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] c;
    logic [7:0] p;
    logic [7:0] pp;
  } beat_t;
  beat_t       q[$];
  logic [23:0] got[NB];
  logic [23:0] exp_last;

  typedef struct {
    int         bx, by, wx, wy;
    int         drive_n;
    int         hold;
    logic [7:0] mi, mj;
    logic       err;
    int         exp_n;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  me_feeder #(
    .BLK_SIZE (BS), .FRAME_W (FW), .FRAME_H (FH), .ADDR_W (AW), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_blk_x (req_blk_x), .req_blk_y (req_blk_y),
    .req_win_x (req_win_x), .req_win_y (req_win_y),
    .cur_addr (cur_addr), .cur_data (cur_data),
    .ref_a_addr (ref_a_addr), .ref_a_data (ref_a_data),
    .ref_b_addr (ref_b_addr), .ref_b_data (ref_b_data),
    .pe_reset (pe_reset), .pe_start (pe_start),
    .pe_c (pe_c), .pe_p (pe_p), .pe_p_prime (pe_p_prime),
    .pe_done (pe_done), .pe_m_i (pe_m_i), .pe_m_j (pe_m_j),
    .res_valid (res_valid), .res_ready (res_ready),
    .res_m_i (res_m_i), .res_m_j (res_m_j), .res_err (res_err)
  );

  // synchronous frame memories: cur[a] = a, ref[a] = a + 1
  always @(posedge clk) begin
    cur_data   <= cur_addr[7:0];
    ref_a_data <= 8'(ref_a_addr + 1'b1);
    ref_b_data <= 8'(ref_b_addr + 1'b1);
  end

  function automatic logic [7:0] cur_pix(input int x, input int y);
    if (x >= FW || y >= FH) return 8'h00;
    return 8'(y * FW + x);
  endfunction

  function automatic logic [7:0] ref_pix(input int x, input int y);
    if (x >= FW || y >= FH) return 8'h00;
    return 8'(y * FW + x + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beats(input int bx, input int by, input int wx, input int wy);
    beat_t b;
    for (int j = 0; j < BS; j++)
      for (int r = 0; r < BS; r++)
        for (int col = 0; col < BS; col++) begin
          b.c  = cur_pix(bx + col, by + r);
          b.p  = ref_pix(wx + BS + j + col, wy + r);
          b.pp = ref_pix(wx + j + col, wy + r);
          q.push_back(b);
        end
  endtask

  // returns at the negedge two cycles after the first STREAM cycle minus one
  task automatic start_job(input int bx, input int by, input int wx, input int wy);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_blk_x = 8'(bx);
    req_blk_y = 8'(by);
    req_win_x = 8'(wx);
    req_win_y = 8'(wy);
    push_beats(bx, by, wx, wy);
    @(negedge clk);
    req_valid = 1'b0;
    check("pe_reset_clr", 32'({req_ready, pe_reset}), 32'b01);
    @(negedge clk);
    check("no_start_stream0", 32'({pe_reset, pe_start}), 32'b00);
    @(negedge clk);
    check("no_start_stream1", 32'(pe_start), 32'd0);
  endtask

  task automatic check_beats(input int n);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = q.pop_front();
      got[k]   = {pe_c, pe_p, pe_p_prime};
      exp_last = {e.c, e.p, e.pp};
      check($sformatf("beat%0d", k), 32'(got[k]), 32'(exp_last));
      if (k < 2) check("pe_start_beat", 32'(pe_start), (k == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic finish_job(input int drive_n, input int exp_n, input logic [7:0] mi,
                            input logic [7:0] mj, input logic err, input int hold);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TO + 20) begin
      @(negedge clk);
      n++;
      if (n == 1) check("hold_last_beat", 32'({pe_c, pe_p, pe_p_prime}), 32'(exp_last));
      if (res_valid) seen = 1'b1;
      else if (n == drive_n) begin
        pe_done = 1'b1;
        pe_m_i  = mi;
        pe_m_j  = mj;
      end
    end
    check("res_latency", 32'(n), 32'(exp_n));
    pe_done = 1'b0;
    if (seen) begin
      check("res_fields", 32'({res_m_i, res_m_j, res_err}), 32'({mi, mj, err}));
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'b1;
        @(negedge clk);
        check("res_hold", 32'({res_valid, req_ready, res_m_i, res_m_j, res_err}),
              32'({1'b1, 1'b0, mi, mj, err}));
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("post_handshake", 32'({res_valid, req_ready, pe_reset}), 32'b010);
      @(negedge clk);
      check("stray_req_dropped", 32'({req_ready, pe_reset}), 32'b10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0,  0,  0,   0,   100, 0,  8'd2,   8'd3, 1'b0, 101};
    vecs[1] = '{0,  0,  14,  0,   5,   0,  8'd1,   8'd4, 1'b0, 6};
    vecs[2] = '{12, 12, 10,  13,  3,   10, 8'd5,   8'd6, 1'b0, 4};
    vecs[3] = '{14, 15, 200, 250, 7,   2,  8'd255, 8'd0, 1'b0, 8};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_blk_x = '0; req_blk_y = '0; req_win_x = '0; req_win_y = '0;
    pe_done   = 1'b0;
    pe_m_i    = '0; pe_m_j = '0;
    res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          32'(|{req_ready, cur_addr, ref_a_addr, ref_b_addr, pe_start, pe_c, pe_p,
                pe_p_prime, res_valid, res_m_i, res_m_j, res_err}), 32'd0);
    check("reset_pe_reset", 32'(pe_reset), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      start_job(vecs[i].bx, vecs[i].by, vecs[i].wx, vecs[i].wy);
      check_beats(NB);
      if (i == 0) check("beat0_anchor", 32'(got[0]), 32'({8'd0, 8'd5, 8'd1}));
      if (i == 1) check("beat5_anchor", 32'(got[5]), 32'({8'd17, 8'd0, 8'd32}));
      finish_job(vecs[i].drive_n, vecs[i].exp_n, vecs[i].mi, vecs[i].mj,
                 vecs[i].err, vecs[i].hold);
    end

    // pe_done never arrives: timeout result with zeroed indices
    pe_m_i = 8'hAA;
    pe_m_j = 8'h55;
    start_job(0, 0, 0, 0);
    check_beats(NB);
    finish_job(-1, TO + 1, 8'd0, 8'd0, 1'b1, 0);

    // reset in the middle of the stream
    start_job(0, 0, 0, 0);
    check_beats(20);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midjob_reset_zero",
          32'(|{req_ready, cur_addr, ref_a_addr, ref_b_addr, pe_start, pe_c, pe_p,
                pe_p_prime, res_valid, res_m_i, res_m_j, res_err}), 32'd0);
    check("midjob_reset_pe_reset", 32'(pe_reset), 32'd1);
    q.delete();
    repeat (2) @(negedge clk);
    check("reset_held", 32'({req_ready, pe_reset, pe_start}), 32'b010);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({req_ready, res_valid, pe_reset}), 32'b100);

    // stale pe_done level before acceptance is ignored until WAIT_DONE
    pe_done = 1'b1;
    pe_m_i  = 8'd7;
    pe_m_j  = 8'd9;
    start_job(1, 2, 3, 4);
    check_beats(NB);
    finish_job(-1, 2, 8'd7, 8'd9, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
